// File: rtl/prog_delay_line.sv
// Runtime-programmable sample delay line built on a circular buffer.
// The ring length follows cur_delay; a load or reset flushes the line.
module prog_delay_line #(
  parameter int WIDTH         = 8,
  parameter int MAX_DEPTH     = 90,
  parameter int DEFAULT_DELAY = 30,
  parameter int DW            = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic [DW-1:0]    delay_in,
  input  logic             delay_load,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [DW-1:0]    cur_delay
);

  logic [WIDTH-1:0] mem [MAX_DEPTH];
  logic [DW-1:0]    ptr;
  logic [DW-1:0]    fill;
  logic [DW-1:0]    clamped;
  logic [WIDTH-1:0] rd;
  logic             adv;

  always_comb begin
    clamped = delay_in;
    unique case (1'b1)
      delay_in == '0:               clamped = DW'(1);
      delay_in > DW'(MAX_DEPTH):    clamped = DW'(MAX_DEPTH);
      default:                      clamped = delay_in;
    endcase
  end

  assign adv = en && !delay_load && !rst;
  assign rd  = mem[ptr];

  // storage carries no reset; dout_valid gating hides stale entries
  always_ff @(posedge clk) begin
    if (adv) mem[ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      fill       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      cur_delay  <= DW'(DEFAULT_DELAY);
    end else if (delay_load) begin
      ptr        <= '0;
      fill       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      cur_delay  <= clamped;
    end else if (en) begin
      ptr <= (ptr == cur_delay - DW'(1)) ? '0 : ptr + DW'(1);
      if (fill == cur_delay) begin
        dout       <= rd;
        dout_valid <= 1'b1;
      end else begin
        dout       <= '0;
        dout_valid <= 1'b0;
        fill       <= fill + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_delay_line.sv
// Randomised bench for prog_delay_line against a queue-based model.
// Each scenario task compares DUT outputs with the model inline.
module tb_prog_delay_line;

  localparam int W  = 8;
  localparam int MD = 90;
  localparam int DW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [W-1:0]  din = '0;
  logic [DW-1:0] delay_in = '0;
  logic          delay_load = 1'b0;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic [DW-1:0] cur_delay;

  int n_checks = 0;
  int n_fail = 0;

  int          m_delay = 30;
  logic [W-1:0] m_dout = '0;
  logic         m_valid = 1'b0;
  logic [W-1:0] q[$];

  prog_delay_line #(
    .WIDTH(W), .MAX_DEPTH(MD), .DEFAULT_DELAY(30)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .delay_in(delay_in), .delay_load(delay_load),
    .dout(dout), .dout_valid(dout_valid), .cur_delay(cur_delay)
  );

  always #5 clk = ~clk;

  // one clock: apply inputs, advance the model, sample 1 time unit later
  task automatic cycle(input logic r, input logic l,
                       input int d, input logic e,
                       input logic [W-1:0] x);
    int v;
    rst = r; delay_load = l; delay_in = DW'(d); en = e; din = x;
    @(posedge clk);
    if (r) begin
      q.delete(); m_delay = 30; m_dout = '0; m_valid = 1'b0;
    end else if (l) begin
      v = d;
      if (v == 0) v = 1;
      if (v > MD) v = MD;
      q.delete(); m_delay = v; m_dout = '0; m_valid = 1'b0;
    end else if (e) begin
      q.push_back(x);
      if (q.size() > m_delay) begin
        m_dout = q.pop_front(); m_valid = 1'b1;
      end else begin
        m_dout = '0; m_valid = 1'b0;
      end
    end
    #1;
    rst = 1'b0; delay_load = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    n_checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || cur_delay !== 7'd30) begin
      n_fail++;
      $display("FAIL reset: dout=%h v=%b cd=%0d expected 00 0 30",
               dout, dout_valid, cur_delay);
    end
    for (int k = 0; k < 40; k++) begin
      cycle(0, 0, 0, 1, W'(k));
      n_checks++;
      if (dout !== m_dout || dout_valid !== m_valid || cur_delay !== 7'd30) begin
        n_fail++;
        $display("FAIL default_stream[%0d]: dout=%h v=%b cd=%0d expected %h %b 30",
                 k, dout, dout_valid, cur_delay, m_dout, m_valid);
      end
      if (k == 29 || k == 30 || k == 31) begin
        n_checks++;
        if (dout_valid !== (k >= 30) || dout !== ((k >= 30) ? W'(k - 30) : 8'h00)) begin
          n_fail++;
          $display("FAIL default_latency[%0d]: dout=%h v=%b", k, dout, dout_valid);
        end
      end
    end
  endtask

  task automatic test_reprogram;
    logic [W-1:0] first;
    cycle(0, 1, 45, 0, 0);
    n_checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || cur_delay !== 7'd45) begin
      n_fail++;
      $display("FAIL reload45: dout=%h v=%b cd=%0d expected 00 0 45",
               dout, dout_valid, cur_delay);
    end
    first = W'($urandom);
    for (int k = 0; k < 50; k++) begin
      cycle(0, 0, 0, 1, (k == 0) ? first : W'($urandom));
      n_checks++;
      if (dout !== m_dout || dout_valid !== m_valid || cur_delay !== 7'd45) begin
        n_fail++;
        $display("FAIL reprog_stream[%0d]: dout=%h v=%b cd=%0d expected %h %b 45",
                 k, dout, dout_valid, cur_delay, m_dout, m_valid);
      end
      if (k == 44 || k == 45) begin
        n_checks++;
        if (dout_valid !== (k == 45) || (k == 45 && dout !== first)) begin
          n_fail++;
          $display("FAIL reprog_refill[%0d]: dout=%h v=%b first=%h",
                   k, dout, dout_valid, first);
        end
      end
    end
  endtask

  task automatic test_stalls;
    logic [W-1:0] ramp;
    logic [W-1:0] pd;
    logic         pv;
    logic         e;
    ramp = '0;
    cycle(0, 1, 4, 0, 0);
    for (int k = 0; k < 80; k++) begin
      pd = dout; pv = dout_valid;
      e = 1'($urandom);
      cycle(0, 0, 0, e, ramp);
      if (e) ramp++;
      n_checks++;
      if (dout !== m_dout || dout_valid !== m_valid || cur_delay !== 7'd4) begin
        n_fail++;
        $display("FAIL stall_stream[%0d]: dout=%h v=%b cd=%0d expected %h %b 4",
                 k, dout, dout_valid, cur_delay, m_dout, m_valid);
      end
      if (!e) begin
        n_checks++;
        if (dout !== pd || dout_valid !== pv) begin
          n_fail++;
          $display("FAIL stall_hold[%0d]: dout=%h v=%b expected %h %b",
                   k, dout, dout_valid, pd, pv);
        end
      end
    end
  endtask

  task automatic test_clamp_extremes;
    int req[3] = '{0, 127, 90};
    int exp_d[3] = '{1, 90, 90};
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, req[i], 0, 0);
      n_checks++;
      if (cur_delay !== DW'(exp_d[i])) begin
        n_fail++;
        $display("FAIL clamp[%0d]: cur_delay=%0d expected %0d",
                 req[i], cur_delay, exp_d[i]);
      end
    end
    cycle(0, 1, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      cycle(0, 0, 0, 1, W'(k + 7));
      n_checks++;
      if (dout_valid !== (k >= 1) || (k >= 1 && dout !== W'(k + 6))) begin
        n_fail++;
        $display("FAIL d1_ramp[%0d]: dout=%h v=%b expected %h %b",
                 k, dout, dout_valid, W'(k + 6), (k >= 1));
      end
    end
    cycle(0, 1, 90, 0, 0);
    for (int k = 0; k < 300; k++) begin
      cycle(0, 0, 0, 1, W'($urandom));
      n_checks++;
      if (dout !== m_dout || dout_valid !== m_valid || cur_delay !== 7'd90) begin
        n_fail++;
        $display("FAIL d90_wrap[%0d]: dout=%h v=%b expected %h %b",
                 k, dout, dout_valid, m_dout, m_valid);
      end
    end
  endtask

  task automatic test_simultaneous;
    cycle(0, 1, 4, 1, 8'hAA);
    for (int k = 0; k < 20; k++) begin
      cycle(0, 0, 0, 1, W'($urandom_range(0, 8'hA9)));
      n_checks++;
      if (dout === 8'hAA || dout !== m_dout || dout_valid !== m_valid) begin
        n_fail++;
        $display("FAIL load_discard[%0d]: dout=%h v=%b expected %h %b",
                 k, dout, dout_valid, m_dout, m_valid);
      end
    end
    cycle(1, 1, 10, 1, 0);
    n_checks++;
    if (cur_delay !== 7'd30 || dout_valid !== 1'b0 || dout !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_vs_load: cd=%0d dout=%h v=%b expected 30 00 0",
               cur_delay, dout, dout_valid);
    end
  endtask

  task automatic test_reset_midfill;
    cycle(0, 1, 60, 0, 0);
    for (int k = 0; k < 20; k++) cycle(0, 0, 0, 1, W'($urandom));
    cycle(1, 0, 0, 1, 8'h55);
    n_checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || cur_delay !== 7'd30) begin
      n_fail++;
      $display("FAIL midfill_reset: dout=%h v=%b cd=%0d expected 00 0 30",
               dout, dout_valid, cur_delay);
    end
    for (int k = 0; k < 33; k++) begin
      cycle(0, 0, 0, 1, W'($urandom));
      n_checks++;
      if (dout !== m_dout || dout_valid !== m_valid || dout_valid !== (k >= 30)) begin
        n_fail++;
        $display("FAIL midfill_refill[%0d]: dout=%h v=%b expected %h %b",
                 k, dout, dout_valid, m_dout, m_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reprogram();
    test_stalls();
    test_clamp_extremes();
    test_simultaneous();
    test_reset_midfill();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
